// File: rtl/stream_decryptor.sv
// stream_decryptor: byte-serial repeating-key subtractive decryptor.
// plain = cipher - key[key_idx] (mod 256), one cycle of latency, with
// MSG_LEN-byte framing that restarts the key schedule at each message.
module stream_decryptor #(
  parameter int MSG_LEN = 20,
  parameter int SEC_LEN = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*SEC_LEN-1:0]   key_in,
  input  logic                   key_load,
  output logic                   key_err,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
  localparam int CNT_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_LEN - 1);

  typedef enum logic {
    NOKEY  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state_q;
  logic [7:0]        key_q [SEC_LEN];
  logic [IDX_W-1:0]  key_idx_q, key_idx_d;
  logic [CNT_W-1:0]  msg_cnt_q, msg_cnt_d;
  logic [7:0]        out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              key_err_q;

  logic              accept;
  logic              msg_end;
  logic              reload_ok;

  // 8-bit modular subtraction; the borrow out of bit 7 is discarded.
  function automatic logic [7:0] sub_mod8(input logic [7:0] a, input logic [7:0] b);
    return a - b;
  endfunction

  // A byte may enter only once a key is held and the output slot is free
  // or being drained this cycle.
  assign in_ready  = (state_q == ACTIVE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign msg_end   = (msg_cnt_q == CNT_LAST);
  // The first load is always taken; later loads only on a message boundary
  // with no byte in flight this cycle, so a message never mixes two keys.
  assign reload_ok = (state_q == NOKEY) || ((msg_cnt_q == '0) && !accept);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign key_err   = key_err_q;

  // Next key index and message position; both move only on acceptance.
  always_comb begin
    key_idx_d = key_idx_q;
    msg_cnt_d = msg_cnt_q;
    if (accept) begin
      if (msg_end) begin
        msg_cnt_d = '0;
        key_idx_d = '0;
      end else begin
        msg_cnt_d = msg_cnt_q + 1'b1;
        key_idx_d = (key_idx_q == IDX_LAST) ? '0 : key_idx_q + 1'b1;
      end
    end
    if (key_load && reload_ok) begin
      msg_cnt_d = '0;
      key_idx_d = '0;
    end
  end

  // Control FSM, key register, counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= NOKEY;
      key_idx_q   <= '0;
      msg_cnt_q   <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      key_err_q   <= 1'b0;
      for (int j = 0; j < SEC_LEN; j++) begin
        key_q[j] <= 8'h00;
      end
    end else begin
      key_idx_q <= key_idx_d;
      msg_cnt_q <= msg_cnt_d;
      key_err_q <= 1'b0;

      if (accept) begin
        out_data_q  <= sub_mod8(in_data, key_q[key_idx_q]);
        out_last_q  <= msg_end;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      case (state_q)
        NOKEY: begin
          if (key_load) begin
            for (int j = 0; j < SEC_LEN; j++) begin
              key_q[j] <= key_in[8*j +: 8];
            end
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (key_load) begin
            if (reload_ok) begin
              for (int j = 0; j < SEC_LEN; j++) begin
                key_q[j] <= key_in[8*j +: 8];
              end
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= NOKEY;
      endcase
    end
  end

endmodule
